// File: rtl/reg_file_mp_if.sv
// Operand/side-channel bus between the control unit/ALU and the reg_file_mp register file.
interface reg_file_mp_if #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16
);
   localparam int AW = $clog2(NUM_REGS);

   logic [DATA_W-1:0] RST_VEC;
   logic              RW;
   logic              BW;
   logic [AW-1:0]     reg_DA;
   logic [AW-1:0]     reg_SA;
   logic [1:0]        As;
   logic [DATA_W-1:0] reg_Din;
   logic              pc_inc;
   logic              sp_push;
   logic              sp_pop;
   logic              sr_we;
   logic [DATA_W-1:0] sr_mask;
   logic [DATA_W-1:0] sr_flags_in;
   logic [DATA_W-1:0] Sout;
   logic [DATA_W-1:0] Dout;
   logic [DATA_W-1:0] reg_PC_out;
   logic [DATA_W-1:0] reg_SP_out;
   logic [DATA_W-1:0] reg_SR_out;
   logic              ready;
   logic              pc_fault;

   modport master (
      output RST_VEC, RW, BW, reg_DA, reg_SA, As, reg_Din,
             pc_inc, sp_push, sp_pop, sr_we, sr_mask, sr_flags_in,
      input  Sout, Dout, reg_PC_out, reg_SP_out, reg_SR_out, ready, pc_fault
   );

   modport slave (
      input  RST_VEC, RW, BW, reg_DA, reg_SA, As, reg_Din,
             pc_inc, sp_push, sp_pop, sr_we, sr_mask, sr_flags_in,
      output Sout, Dout, reg_PC_out, reg_SP_out, reg_SR_out, ready, pc_fault
   );
endinterface

// File: rtl/reg_file_mp.sv
// MSP430-class register file: post-reset clearing sequencer, PC/SP/SR side channels,
// byte-write masking, write-to-read bypass and constant generator on the source port.
module reg_file_mp #(
   parameter int               DATA_W   = 16,
   parameter int               NUM_REGS = 16,
   parameter logic [DATA_W-1:0] PC_MIN  = DATA_W'(16'h0200),
   parameter logic [DATA_W-1:0] SP_RST  = DATA_W'(16'h0400),
   parameter bit               BYPASS   = 1'b1
) (
   input logic            clk,
   input logic            rst,
   reg_file_mp_if.slave   bus
);
   localparam int AW = $clog2(NUM_REGS);
   localparam logic [AW-1:0]     A_PC  = AW'(0);
   localparam logic [AW-1:0]     A_SP  = AW'(1);
   localparam logic [AW-1:0]     A_SR  = AW'(2);
   localparam logic [AW-1:0]     A_CG  = AW'(3);
   localparam logic [AW-1:0]     A_FST = AW'(4);
   localparam logic [AW-1:0]     A_LST = AW'(NUM_REGS-1);
   localparam logic [DATA_W-1:0] TWO   = DATA_W'(2);
   localparam logic [DATA_W-1:0] ALIGN = ~(DATA_W'(1));

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t            r_state;
   logic [AW-1:0]     r_idx;
   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic              r_ready;
   logic              r_pc_fault;

   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_r0_wval;
   logic [DATA_W-1:0] w_r1_wval;
   logic [DATA_W-1:0] w_wr_val;
   logic              w_wr_en;
   logic              w_r0_fault;
   logic              w_byp_da;
   logic              w_byp_sa;

   // Write data shaping; w_wr_val is what the addressed register will actually hold.
   always_comb begin
      w_wdata    = bus.BW ? {{(DATA_W-8){1'b0}}, bus.reg_Din[7:0]} : bus.reg_Din;
      w_wr_en    = (r_state == ST_RUN) && bus.RW;
      w_r0_fault = (w_wdata < PC_MIN);
      w_r0_wval  = w_r0_fault ? bus.RST_VEC : (w_wdata & ALIGN);
      w_r1_wval  = w_wdata & ALIGN;
      case (bus.reg_DA)
         A_PC:    w_wr_val = w_r0_wval;
         A_SP:    w_wr_val = w_r1_wval;
         default: w_wr_val = w_wdata;
      endcase
      w_byp_da = BYPASS && w_wr_en && (bus.reg_DA != A_CG);
      w_byp_sa = w_byp_da && (bus.reg_SA == bus.reg_DA);
   end

   // Destination read port: R3 is hard-wired zero.
   always_comb begin
      if (bus.reg_DA == A_CG) begin
         bus.Dout = '0;
      end else if (w_byp_da) begin
         bus.Dout = w_wr_val;
      end else begin
         bus.Dout = r_regs[bus.reg_DA];
      end
   end

   // Source read port: constant generator on R2/R3 overrides register and bypass data.
   always_comb begin
      if (bus.reg_SA == A_CG) begin
         case (bus.As)
            2'b00:   bus.Sout = '0;
            2'b01:   bus.Sout = DATA_W'(1);
            2'b10:   bus.Sout = DATA_W'(2);
            default: bus.Sout = '1;
         endcase
      end else if ((bus.reg_SA == A_SR) && (bus.As != 2'b00)) begin
         case (bus.As)
            2'b01:   bus.Sout = '0;
            2'b10:   bus.Sout = DATA_W'(4);
            default: bus.Sout = DATA_W'(8);
         endcase
      end else if (w_byp_sa) begin
         bus.Sout = w_wr_val;
      end else begin
         bus.Sout = r_regs[bus.reg_SA];
      end
   end

   // Sequencer FSM and all register updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_INIT;
         r_idx      <= A_FST;
         r_ready    <= 1'b0;
         r_pc_fault <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
         r_regs[0] <= bus.RST_VEC;
         r_regs[1] <= SP_RST;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_regs[r_idx] <= '0;
               r_idx         <= r_idx + AW'(1);
               r_pc_fault    <= 1'b0;
               if (r_idx == A_LST) begin
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_wr_en && (bus.reg_DA == A_PC)) begin
                  r_regs[0]  <= w_r0_wval;
                  r_pc_fault <= w_r0_fault;
               end else begin
                  r_pc_fault <= 1'b0;
                  if (bus.pc_inc) begin
                     r_regs[0] <= r_regs[0] + TWO;
                  end
               end
               // Simultaneous push and pop cancel out.
               if (w_wr_en && (bus.reg_DA == A_SP)) begin
                  r_regs[1] <= w_r1_wval;
               end else if (bus.sp_push && !bus.sp_pop) begin
                  r_regs[1] <= r_regs[1] - TWO;
               end else if (bus.sp_pop && !bus.sp_push) begin
                  r_regs[1] <= r_regs[1] + TWO;
               end
               if (w_wr_en && (bus.reg_DA == A_SR)) begin
                  r_regs[2] <= w_wdata;
               end else if (bus.sr_we) begin
                  r_regs[2] <= (r_regs[2] & ~bus.sr_mask) | (bus.sr_flags_in & bus.sr_mask);
               end
               if (w_wr_en && (bus.reg_DA > A_CG)) begin
                  r_regs[bus.reg_DA] <= w_wdata;
               end
               r_regs[3] <= '0;
            end
            default: begin
               r_state <= ST_INIT;
               r_idx   <= A_FST;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign bus.reg_PC_out = r_regs[0];
   assign bus.reg_SP_out = r_regs[1];
   assign bus.reg_SR_out = r_regs[2];
   assign bus.ready      = r_ready;
   assign bus.pc_fault   = r_pc_fault;
endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: expected values are queued when stimulus is
// driven and popped when the corresponding output is sampled.
module tb_reg_file_mp;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [15:0] exp_q [$];
   logic [15:0] exp_v;

   reg_file_mp_if #(.DATA_W(16), .NUM_REGS(16)) bus ();

   reg_file_mp #(
      .DATA_W(16), .NUM_REGS(16), .PC_MIN(16'h0200), .SP_RST(16'h0400), .BYPASS(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.RW = 1'b0;  bus.BW = 1'b0;  bus.reg_DA = 4'd0;  bus.reg_SA = 4'd0;
      bus.As = 2'b00; bus.reg_Din = 16'h0000; bus.pc_inc = 1'b0;
      bus.sp_push = 1'b0; bus.sp_pop = 1'b0; bus.sr_we = 1'b0;
      bus.sr_mask = 16'h0000; bus.sr_flags_in = 16'h0000;
   endtask

   task automatic test_reset();
      idle();
      bus.RST_VEC = 16'hC000;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.push_back(16'hC000);
      exp_v = exp_q.pop_front(); n_checks++;
      if (bus.reg_PC_out !== exp_v) $display("FAIL reset_pc got %h exp %h", bus.reg_PC_out, exp_v); else n_pass++;
      exp_q.push_back(16'h0400);
      exp_v = exp_q.pop_front(); n_checks++;
      if (bus.reg_SP_out !== exp_v) $display("FAIL reset_sp got %h exp %h", bus.reg_SP_out, exp_v); else n_pass++;
      exp_q.push_back(16'h0000);
      exp_v = exp_q.pop_front(); n_checks++;
      if (bus.reg_SR_out !== exp_v) $display("FAIL reset_sr got %h exp %h", bus.reg_SR_out, exp_v); else n_pass++;
      // Writes to R5 during INIT must be ignored.
      bus.RW = 1'b1; bus.reg_DA = 4'd5; bus.reg_Din = 16'hFFFF;
      for (int k = 0; k <= 12; k++) begin
         exp_q.push_back((k < 12) ? 16'h0000 : 16'h0001);
         exp_v = exp_q.pop_front(); n_checks++;
         if ({15'd0, bus.ready} !== exp_v) $display("FAIL init_ready cyc %0d got %h exp %h", k, bus.ready, exp_v); else n_pass++;
         if (k < 12) tick();
      end
      bus.RW = 1'b0;
      for (int a = 4; a < 16; a++) begin
         bus.reg_DA = 4'(a);
         exp_q.push_back(16'h0000);
         #1;
         exp_v = exp_q.pop_front(); n_checks++;
         if (bus.Dout !== exp_v) $display("FAIL init_clear R%0d got %h exp %h", a, bus.Dout, exp_v); else n_pass++;
      end
   endtask

   task automatic test_bypass();
      idle();
      bus.RW = 1'b1; bus.BW = 1'b1; bus.reg_DA = 4'd5; bus.reg_Din = 16'hABCD; bus.reg_SA = 4'd5;
      exp_q.push_back(16'h00CD);
      #1;
      exp_v = exp_q.pop_front(); n_checks++;
      if (bus.Sout !== exp_v) $display("FAIL bypass_sout got %h exp %h", bus.Sout, exp_v); else n_pass++;
      tick();
      bus.RW = 1'b0; bus.BW = 1'b0; bus.reg_SA = 4'd0;
      exp_q.push_back(16'h00CD);
      #1;
      exp_v = exp_q.pop_front(); n_checks++;
      if (bus.Dout !== exp_v) $display("FAIL written_dout got %h exp %h", bus.Dout, exp_v); else n_pass++;
   endtask

   task automatic test_pc();
      idle();
      bus.RW = 1'b1; bus.reg_DA = 4'd0; bus.reg_Din = 16'h0100; bus.reg_SA = 4'd0;
      exp_q.push_back(16'hC000);
      #1;
      exp_v = exp_q.pop_front(); n_checks++;
      if (bus.Sout !== exp_v) $display("FAIL pc_fault_bypass got %h exp %h", bus.Sout, exp_v); else n_pass++;
      tick();
      idle();
      exp_q.push_back(16'hC000);
      exp_q.push_back(16'h0001);
      exp_v = exp_q.pop_front(); n_checks++;
      if (bus.reg_PC_out !== exp_v) $display("FAIL pc_fault_vec got %h exp %h", bus.reg_PC_out, exp_v); else n_pass++;
      exp_v = exp_q.pop_front(); n_checks++;
      if ({15'd0, bus.pc_fault} !== exp_v) $display("FAIL pc_fault_hi got %h exp %h", bus.pc_fault, exp_v); else n_pass++;
      tick();
      exp_q.push_back(16'h0000);
      exp_v = exp_q.pop_front(); n_checks++;
      if ({15'd0, bus.pc_fault} !== exp_v) $display("FAIL pc_fault_pulse got %h exp %h", bus.pc_fault, exp_v); else n_pass++;
      // General write outranks pc_inc and is aligned.
      bus.RW = 1'b1; bus.reg_DA = 4'd0; bus.reg_Din = 16'hE001; bus.pc_inc = 1'b1;
      tick();
      idle();
      exp_q.push_back(16'hE000);
      exp_q.push_back(16'h0000);
      exp_v = exp_q.pop_front(); n_checks++;
      if (bus.reg_PC_out !== exp_v) $display("FAIL pc_write_prio got %h exp %h", bus.reg_PC_out, exp_v); else n_pass++;
      exp_v = exp_q.pop_front(); n_checks++;
      if ({15'd0, bus.pc_fault} !== exp_v) $display("FAIL pc_no_fault got %h exp %h", bus.pc_fault, exp_v); else n_pass++;
      bus.pc_inc = 1'b1;
      tick();
      idle();
      exp_q.push_back(16'hE002);
      exp_v = exp_q.pop_front(); n_checks++;
      if (bus.reg_PC_out !== exp_v) $display("FAIL pc_inc got %h exp %h", bus.reg_PC_out, exp_v); else n_pass++;
   endtask

   task automatic test_sp();
      logic [15:0] din_t  [5] = '{16'h0000, 16'h0000, 16'h0500, 16'hFFFF, 16'h0000};
      logic        rw_t   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic        push_t [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic        pop_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [15:0] exp_t  [5] = '{16'h03FE, 16'h03FE, 16'h0500, 16'hFFFE, 16'h0000};
      for (int s = 0; s < 5; s++) begin
         idle();
         bus.RW = rw_t[s]; bus.reg_DA = 4'd1; bus.reg_Din = din_t[s];
         bus.sp_push = push_t[s]; bus.sp_pop = pop_t[s];
         exp_q.push_back(exp_t[s]);
         tick();
         idle();
         exp_v = exp_q.pop_front(); n_checks++;
         if (bus.reg_SP_out !== exp_v) $display("FAIL sp_step %0d got %h exp %h", s, bus.reg_SP_out, exp_v); else n_pass++;
      end
   endtask

   task automatic test_sr();
      logic [15:0] mask_t [3] = '{16'h0007, 16'h0004, 16'hFFFF};
      logic [15:0] flg_t  [3] = '{16'h0005, 16'h0000, 16'hFFFF};
      logic        rw_t   [3] = '{1'b0, 1'b0, 1'b1};
      logic [15:0] exp_t  [3] = '{16'h0005, 16'h0001, 16'h0100};
      for (int s = 0; s < 3; s++) begin
         idle();
         bus.sr_we = 1'b1; bus.sr_mask = mask_t[s]; bus.sr_flags_in = flg_t[s];
         bus.RW = rw_t[s]; bus.reg_DA = 4'd2; bus.reg_Din = 16'h0100;
         exp_q.push_back(exp_t[s]);
         tick();
         idle();
         exp_v = exp_q.pop_front(); n_checks++;
         if (bus.reg_SR_out !== exp_v) $display("FAIL sr_step %0d got %h exp %h", s, bus.reg_SR_out, exp_v); else n_pass++;
      end
   endtask

   task automatic test_constgen();
      logic [15:0] cg3 [4] = '{16'h0000, 16'h0001, 16'h0002, 16'hFFFF};
      logic [15:0] cg2 [4] = '{16'h0100, 16'h0000, 16'h0004, 16'h0008};
      idle();
      for (int m = 0; m < 4; m++) begin
         bus.reg_SA = 4'd3; bus.As = 2'(m);
         exp_q.push_back(cg3[m]);
         #1;
         exp_v = exp_q.pop_front(); n_checks++;
         if (bus.Sout !== exp_v) $display("FAIL cg_r3 as%0d got %h exp %h", m, bus.Sout, exp_v); else n_pass++;
         bus.reg_SA = 4'd2;
         exp_q.push_back(cg2[m]);
         #1;
         exp_v = exp_q.pop_front(); n_checks++;
         if (bus.Sout !== exp_v) $display("FAIL cg_r2 as%0d got %h exp %h", m, bus.Sout, exp_v); else n_pass++;
      end
      idle();
      bus.RW = 1'b1; bus.reg_DA = 4'd3; bus.reg_Din = 16'h1234; bus.reg_SA = 4'd3;
      exp_q.push_back(16'h0000);
      #1;
      exp_v = exp_q.pop_front(); n_checks++;
      if (bus.Sout !== exp_v) $display("FAIL r3_no_bypass got %h exp %h", bus.Sout, exp_v); else n_pass++;
      tick();
      bus.RW = 1'b0;
      exp_q.push_back(16'h0000);
      #1;
      exp_v = exp_q.pop_front(); n_checks++;
      if (bus.Dout !== exp_v) $display("FAIL r3_zero got %h exp %h", bus.Dout, exp_v); else n_pass++;
   endtask

   task automatic test_mid_init_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back(16'h0000);
         exp_v = exp_q.pop_front(); n_checks++;
         if ({15'd0, bus.ready} !== exp_v) $display("FAIL mid_ready cyc %0d got %h exp %h", k, bus.ready, exp_v); else n_pass++;
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.push_back(16'hC000);
      exp_v = exp_q.pop_front(); n_checks++;
      if (bus.reg_PC_out !== exp_v) $display("FAIL rerst_pc got %h exp %h", bus.reg_PC_out, exp_v); else n_pass++;
      for (int k = 0; k <= 12; k++) begin
         exp_q.push_back((k < 12) ? 16'h0000 : 16'h0001);
         exp_v = exp_q.pop_front(); n_checks++;
         if ({15'd0, bus.ready} !== exp_v) $display("FAIL rerst_ready cyc %0d got %h exp %h", k, bus.ready, exp_v); else n_pass++;
         if (k < 12) tick();
      end
      bus.reg_DA = 4'd5;
      exp_q.push_back(16'h0000);
      #1;
      exp_v = exp_q.pop_front(); n_checks++;
      if (bus.Dout !== exp_v) $display("FAIL rerst_r5 got %h exp %h", bus.Dout, exp_v); else n_pass++;
   endtask

   initial begin
      bus.RST_VEC = 16'hC000;
      idle();
      test_reset();
      test_bypass();
      test_pc();
      test_sp();
      test_sr();
      test_constgen();
      test_mid_init_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
